// File: rtl/accel_frame_bridge.sv
// Accelerometer conditioning bridge: per-channel moving average with deadband hold,
// published to the renderer only on vsync falling edges. Define CALIB_OFFSET_EN for offset calibration.

module accel_frame_bridge_lane #(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 3,
    parameter int DEADBAND = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                cal_en,
    input  logic [AVG_LOG2-1:0] wp,
    input  logic [DATA_W-1:0]   sample,
    output logic [DATA_W-1:0]   held
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0]        hist [DEPTH];
    logic [DATA_W-1:0]        old;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  new_sum;
    logic signed [DATA_W-1:0] avg;
    logic signed [DATA_W-1:0] cand;
    logic [DATA_W:0]          delta;
    logic [DATA_W:0]          mag;
    logic                     upd;

    assign old     = hist[wp];
    assign new_sum = sum - $signed({{AVG_LOG2{old[DATA_W-1]}}, old})
                         + $signed({{AVG_LOG2{sample[DATA_W-1]}}, sample});
    // Dropping the low bits of a two's complement sum is a floor divide.
    assign avg     = new_sum[SUM_W-1:AVG_LOG2];

`ifdef CALIB_OFFSET_EN
    logic signed [DATA_W-1:0] offset;
    logic [DATA_W:0]          corr;

    assign corr = {avg[DATA_W-1], avg} - {offset[DATA_W-1], offset};

    always_comb begin
        cand = corr[DATA_W-1:0];
        if (corr[DATA_W] != corr[DATA_W-1])
            cand = corr[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            offset <= '0;
        else if (cal_en)
            offset <= $signed(held) + offset;
    end
`else
    logic unused_cal;
    assign unused_cal = cal_en;
    assign cand       = avg;
`endif

    // One extra bit keeps the difference of two DATA_W values exact.
    assign delta = {cand[DATA_W-1], cand} - {held[DATA_W-1], held};
    assign mag   = delta[DATA_W] ? (~delta + (DATA_W+1)'(1)) : delta;
    assign upd   = mag > (DATA_W+1)'(DEADBAND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            held <= '0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (en) begin
            sum      <= new_sum;
            hist[wp] <= sample;
            if (upd) held <= cand;
        end
    end
endmodule

module accel_frame_bridge #(
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 3,
    parameter int DEADBAND = 4
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     RST_N,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     vga_vs,
    input  logic                     cal_req,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     busy,
    output logic [7:0]               drop_cnt
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_COMMIT, S_CAL} state_t;

    state_t                    state;
    logic [CH_W-1:0]           ch;
    logic [AVG_LOG2-1:0]       wp;
    logic [NUM_CH*DATA_W-1:0]  smp;
    logic [NUM_CH*DATA_W-1:0]  held_flat;
    logic                      vs_prev;
    logic                      vs_fall;
    logic                      cal_en;

`ifdef CALIB_OFFSET_EN
    assign cal_en = (state == S_CAL);
`else
    logic unused_req;
    assign unused_req = cal_req;
    assign cal_en     = 1'b0;
`endif

    always_ff @(posedge MAX10_CLK1_50 or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            ch       <= '0;
            wp       <= '0;
            smp      <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (in_valid && state != S_IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                S_IDLE:
                    if (in_valid) begin
                        smp   <= in_data;
                        ch    <= '0;
                        state <= S_PROC;
                        busy  <= 1'b1;
                    end
`ifdef CALIB_OFFSET_EN
                    else if (cal_req) begin
                        state <= S_CAL;
                        busy  <= 1'b1;
                    end
`endif
                S_PROC:
                    if (ch == LAST_CH) state <= S_COMMIT;
                    else               ch    <= ch + CH_W'(1);
                S_COMMIT: begin
                    wp    <= wp + AVG_LOG2'(1);
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        accel_frame_bridge_lane #(
            .DATA_W  (DATA_W),
            .AVG_LOG2(AVG_LOG2),
            .DEADBAND(DEADBAND)
        ) u_lane (
            .clk   (MAX10_CLK1_50),
            .rst_n (RST_N),
            .en    (state == S_PROC && ch == CH_W'(c)),
            .cal_en(cal_en),
            .wp    (wp),
            .sample(smp[c*DATA_W +: DATA_W]),
            .held  (held_flat[c*DATA_W +: DATA_W])
        );
    end

    // Snapshot held values at the edge cycle; lanes updating that same edge show their old value.
    assign vs_fall = vs_prev & ~vga_vs;

    always_ff @(posedge MAX10_CLK1_50 or negedge RST_N) begin
        if (!RST_N) begin
            vs_prev   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            vs_prev   <= vga_vs;
            out_valid <= vs_fall;
            if (vs_fall) out_data <= held_flat;
        end
    end
endmodule

// File: tb/tb_accel_frame_bridge.sv
// Directed bench for accel_frame_bridge (2 channels, 16-bit, window 8, deadband 4).
module tb_accel_frame_bridge;
    localparam int NC = 2;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC*DW-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              vga_vs = 1'b1;
    logic              cal_req = 1'b0;
    logic [NC*DW-1:0]  out_data;
    logic              out_valid;
    logic              busy;
    logic [7:0]        drop_cnt;
    int                n_chk = 0;
    int                n_err = 0;

    accel_frame_bridge #(.NUM_CH(NC), .DATA_W(DW), .AVG_LOG2(3), .DEADBAND(4)) dut (
        .MAX10_CLK1_50(clk),
        .RST_N        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .vga_vs       (vga_vs),
        .cal_req      (cal_req),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] och(input int c);
        logic signed [DW-1:0] v;
        v = out_data[c*DW +: DW];
        return 32'(v);
    endfunction

    task automatic set_in(input int a, input int b);
        in_data = {DW'(b), DW'(a)};
    endtask

    // One accepted strobe; returns aligned to posedge+1 with the FSM back in IDLE.
    task automatic strobe(input int a, input int b);
        set_in(a, b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) strobe(a, b);
    endtask

    task automatic vs_pulse(input string tag, input int e0, input int e1);
        vga_vs = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 1);
        chk({tag, "_ch0"}, och(0), e0);
        chk({tag, "_ch1"}, och(1), e1);
        vga_vs = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_vld_off"}, 32'(out_valid), 0);
        chk({tag, "_hold"}, och(0), e0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out_data), 0);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vs_pulse("rst_f1", 0, 0);
        repeat (3) @(posedge clk);
        #1;
        vs_pulse("rst_f2", 0, 0);
        chk("rst_drop2", 32'(drop_cnt), 0);

        // Ramp-in over the window
        strobes(4, 80, -80);
        vs_pulse("avg4", 40, -40);
        strobes(4, 80, -80);
        vs_pulse("avg8", 80, -80);

        // Deadband: 103 never moves a hold of 100, 110 does
        strobes(8, 100, -100);
        vs_pulse("db100", 100, -100);
        strobes(8, 103, -103);
        vs_pulse("db103", 100, -100);
        strobes(8, 110, -110);
        vs_pulse("db110", 110, -110);

        // Strobe every 3 cycles: every second one lands while busy
        for (int i = 0; i < 4; i++) begin
            set_in(200, -200);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i == 0) chk("drop_busy", 32'(busy), 1);
            chk("drop_stable", och(0), 110);
            chk("drop_novld", 32'(out_valid), 0);
            @(posedge clk);
            @(posedge clk); #1;
        end
        chk("drop_cnt2", 32'(drop_cnt), 2);
        chk("drop_idle", 32'(busy), 0);
        vs_pulse("drop_pub", 132, -133);

        // vs edge on the cycle ch0 is processed: frame shows old values
        set_in(400, -400);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vga_vs = 1'b0;
        @(posedge clk); #1;
        chk("mid_vld", 32'(out_valid), 1);
        chk("mid_ch0", och(0), 132);
        chk("mid_ch1", och(1), -133);
        vga_vs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_hold", och(1), -133);
        vs_pulse("mid_next", 168, -169);

`ifdef CALIB_OFFSET_EN
        strobes(8, 500, 0);
        vs_pulse("cal_pre", 500, 0);
        cal_req = 1'b1;
        @(posedge clk); #1;
        cal_req = 1'b0;
        chk("cal_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("cal_idle", 32'(busy), 0);
        strobes(8, 500, 0);
        vs_pulse("cal_zero", 0, 0);
        strobes(8, 520, 0);
        vs_pulse("cal_20", 20, 0);
`endif

        // Continuous strobes saturate the drop counter
        set_in(0, 0);
        in_valid = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("drop_sat", 32'(drop_cnt), 255);

        // Reset in the middle of PROC clears everything
        set_in(50, -50);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_drop", 32'(drop_cnt), 0);
        chk("mrst_out", 32'(out_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vs_pulse("mrst_pub", 0, 0);
        strobe(80, -80);
        vs_pulse("mrst_clean", 10, -10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/accel_frame_bridge.md
Name: accel_frame_bridge

Overview:
Parametrised conditioning stage between the accelerometer reader and the VGA renderer. It takes NUM_CH signed axis samples per strobe and runs a per-channel moving average. A deadband hold suppresses jitter. Conditioned values are published only at the start of each vertical sync, so the renderer never sees a change mid-frame.

Parameters:
NUM_CH, 2, number of axis channels (1..4)
DATA_W, 16, signed sample width per channel
AVG_LOG2, 3, log2 of moving-average depth (window = 2^AVG_LOG2 samples)
DEADBAND, 4, minimum |avg - held| (LSBs) needed to update the held value

Ports:
MAX10_CLK1_50  in   1                clock, 50 MHz
RST_N          in   1                asynchronous active-low reset (top-level ties to KEY[0])
in_data        in   NUM_CH*DATA_W    channel c at bits [c*DATA_W +: DATA_W], two's complement
in_valid       in   1                one-cycle sample strobe
vga_vs         in   1                VGA vertical sync, active low, same clock domain
cal_req        in   1                one-cycle calibration request (see Optional Feature)
out_data       out  NUM_CH*DATA_W    frame-stable conditioned values, same packing as in_data
out_valid      out  1                one-cycle pulse when out_data is updated
busy           out  1                high while FSM is not IDLE
drop_cnt       out  8                saturating count of dropped samples

Behaviour:
- Reset (async assert, sync release): all outputs 0. Sample buffers, running sums, held values and offsets are cleared. FSM goes to IDLE.
- Storage per channel: circular buffer of 2^AVG_LOG2 samples, write pointer shared across channels. Running sum is DATA_W+AVG_LOG2 bits, signed.
- FSM states:
  - IDLE: on in_valid, register all of in_data, then go to PROC with ch=0.
  - PROC: handles one channel per cycle.
    - sum <= sum - buf[wp] + sample.
    - buf[wp] <= sample.
    - avg = new_sum >>> AVG_LOG2 (arithmetic shift; truncates toward -inf).
    - If |avg - held[ch]| > DEADBAND, then held[ch] <= avg. Compare at DATA_W+1 bits so it cannot overflow.
    - ch increments. After ch=NUM_CH-1, go to COMMIT.
  - COMMIT: wp <= wp+1, wrapping modulo 2^AVG_LOG2. Return to IDLE.
- Latency from in_valid to held values updated: NUM_CH+1 cycles. busy is high for exactly NUM_CH+1 cycles.
- An in_valid arriving while busy is dropped and drop_cnt increments, saturating at 255. No queueing.
- Warm-up: the buffer starts at zero, so the average ramps in over the first 2^AVG_LOG2 samples. There is no special-casing.
- Frame publish:
  - Detect the vga_vs falling edge using a registered previous value.
  - On the following cycle, out_data <= held (all channels simultaneously) and out_valid pulses for 1 cycle.
  - out_data changes at no other time.
- Simultaneous events:
  - vs edge during PROC: publish uses held values as of the edge cycle. Channels not yet processed show their old value; no stall.
  - vs edge on the same cycle as in_valid: both are accepted.
- No vs edges: out_data holds indefinitely and out_valid stays 0.
- Reset mid-PROC: everything is cleared and no partial publish occurs.

Optional Feature:
Macro CALIB_OFFSET_EN.
- Defined:
  - A per-channel DATA_W offset register exists, reset to 0.
  - When cal_req is seen in IDLE, each offset[c] <= held[c] + offset[c], i.e. the current uncorrected average. Capture takes 1 cycle and busy is high during it.
  - In PROC, avg is replaced by avg - offset[c] and saturated to the DATA_W signed range.
  - A cal_req while busy is ignored and not counted.
- Not defined: no offset registers exist, cal_req is unused, and arithmetic is as above.

Test Plan:
1. Reset behaviour: hold RST_N=0, then release with no strobes and toggle vga_vs -> out_data=0 every frame, out_valid pulses once per vs falling edge, drop_cnt=0.
2. Averaging: NUM_CH=2, 8 strobes with ch0=+80 and ch1=-80, then a vs edge -> out_data ch0=+80, ch1=-80. After the 4th strobe a publish shows ch0=+40, ch1=-40.
3. Deadband: settle at 100, then 8 strobes of 103 and a vs edge -> out 100 (unchanged). Then 8 strobes of 110 -> out 110.
4. Frame stability: strobe every 3 cycles with busy=3 -> every second strobe lands while busy, drop_cnt increments. out_data changes only on the cycle after a vs falling edge.
5. Mid-frame ordering: vs edge asserted on the cycle PROC handles ch0 -> published ch0 is old, ch1 is old, and the next frame carries both new values.
6. (CALIB_OFFSET_EN) Settle at ch0=+500, pulse cal_req, 8 further strobes of 500 -> out ch0=0. Then strobes of 520 -> out ch0=+20.
